serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port A, input, WIDTH bits: first operand; captured when start is accepted.
REQ-006 SHALL have port B, input, WIDTH bits: second operand; captured when start is accepted.
REQ-007 SHALL have port Cin, input, 1 bit: carry-in; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-010 SHALL have port Sum, output, WIDTH bits: registered result of A+B+Cin, low WIDTH bits.
REQ-011 SHALL have port Cout, output, 1 bit: registered carry-out of the last completed addition.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE (busy=0), latching A, B and Cin into internal shift registers and the carry flop, clearing the bit counter, and entering RUN.
REQ-014 SHALL, on each RUN cycle, add LSB bits A_sr[0], B_sr[0] and the carry flop; shift the sum bit into the result shift register from the MSB side; shift A_sr and B_sr right by one; load the carry flop with the bit carry-out; and increment the counter.
REQ-015 SHALL remain in RUN for exactly WIDTH cycles, then enter DONE, loading Sum from the result shift register and Cout from the final carry.
REQ-016 SHALL assert busy exactly in RUN, i.e. for WIDTH cycles starting the cycle after start is accepted.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unless start is accepted in that cycle.
REQ-018 SHALL ignore start while busy=1: no recapture of operands and no change to the count.
REQ-019 SHALL hold Sum and Cout stable from one DONE until the next DONE, including through RUN.
REQ-020 SHALL use a counter of $clog2(WIDTH+1) bits; the result SHALL equal (A+B+Cin) mod 2^WIDTH, with Cout as bit WIDTH.

Reset
REQ-021 SHALL, while rst=1 and independent of clk, force the state to IDLE; busy, done, Sum, Cout, the counter, the carry flop and all shift registers to 0.
REQ-022 SHALL abandon any addition in progress when reset is asserted mid-operation and SHALL produce no done pulse for it.

Configuration
REQ-023 SHALL, when macro SERIAL_ADDER_OVF_EN is defined, add output port Ovf (1 bit), registered in DONE as the signed two's-complement overflow (carry into MSB XOR carry out of MSB), reset to 0, and held like Sum.
REQ-024 SHALL, when SERIAL_ADDER_OVF_EN is undefined, have no Ovf port and no associated logic; all other behaviour is identical.

Structure
REQ-025 SHALL take its FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant from shared package serial_adder_pkg.
REQ-026 SHALL instantiate exactly one existing full_adder sub-module (ports A, B, Cin, Sum, Cout) as the per-bit adder; no other arithmetic operator SHALL form the sum.

Verification
REQ-027 SHALL check WIDTH=8, A=3, B=5, Cin=0, start -> busy for 8 cycles, then done pulse with Sum=8, Cout=0.
REQ-028 SHALL check A=255, B=1, Cin=0 -> Sum=0, Cout=1; then A=255, B=255, Cin=1 -> Sum=255, Cout=1.
REQ-029 SHALL check start pulsed with A=9, B=9 during the 4th busy cycle of a 1+2 operation -> result Sum=3; the second start is ignored; busy length is unchanged.
REQ-030 SHALL check rst asserted in the 5th RUN cycle -> all outputs 0 immediately, no done pulse, and a new start after release gives the correct result.
REQ-031 SHALL check, with SERIAL_ADDER_OVF_EN defined, 127+1 -> Sum=128, Ovf=1, and 100+(-50) -> Sum=50, Ovf=0.
REQ-032 SHALL check WIDTH=3 exhaustively over all A, B and Cin (128 cases) against a reference sum, with back-to-back start accepted in DONE.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the per-bit adder of serial_adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single full_adder, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output Ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             Ovf,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   finish;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 bits already produced; the final bit joins them in res_next.
    logic [WIDTH-1:1] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    assign res_next = {fa_sum, res_sr};
    assign finish   = (state == RUN) && (cnt == LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_next[WIDTH-1:1];
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            // Outputs change only as DONE is entered, so they hold through RUN.
            if (finish) begin
                Sum  <= res_next;
                Cout <= fa_cout;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last bit, carry is the carry into the MSB and fa_cout the carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Ovf <= 1'b0;
        end else if (finish) begin
            Ovf <= carry ^ fa_cout;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for the directed tests and
// a 3-bit instance for the exhaustive back-to-back sweep.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf8;
    logic ovf3;
`endif

    logic [8:0] exp_q[$];
    logic       exp_ovf_q[$];
    logic [3:0] exp3_q[$];
    logic       exp_ovf3_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
`ifdef SERIAL_ADDER_OVF_EN
        .Ovf   (ovf8),
`endif
        .Sum   (sum8),
        .Cout  (cout8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .A     (a3),
        .B     (b3),
        .Cin   (cin3),
        .busy  (busy3),
        .done  (done3),
`ifdef SERIAL_ADDER_OVF_EN
        .Ovf   (ovf3),
`endif
        .Sum   (sum3),
        .Cout  (cout3)
    );

    // Driver: issue one 8-bit addition, push its expectation, then watch for done.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output int busy_n, output logic seen_done, output logic held_ok);
        logic [7:0] pre_sum;
        logic       pre_cout;
        logic [8:0] full;
        @(negedge clk);
        pre_sum  = sum8;
        pre_cout = cout8;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        full = {1'b0, a} + {1'b0, b} + {8'd0, c};
        exp_q.push_back(full);
        exp_ovf_q.push_back((a[7] == b[7]) && (full[7] != a[7]));
        @(posedge clk);
        #1 start8 = 1'b0;
        busy_n = 0; seen_done = 1'b0; held_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy8) begin
                busy_n++;
                if (sum8 !== pre_sum || cout8 !== pre_cout) held_ok = 1'b0;
            end
            if (done8) begin
                seen_done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy8, done8, cout8, sum8} !== 11'd0)
            $display("FAIL reset8: busy=%b done=%b cout=%b sum=%0d, required all 0", busy8, done8, cout8, sum8);
        else pass_cnt++;
        total_cnt++;
        if ({busy3, done3, cout3, sum3} !== 6'd0)
            $display("FAIL reset3: busy=%b done=%b cout=%b sum=%0d, required all 0", busy3, done3, cout3, sum3);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total_cnt++;
        if (ovf8 !== 1'b0) $display("FAIL reset_ovf: ovf=%b, required 0", ovf8);
        else pass_cnt++;
`endif
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy8 !== 1'b0 || done8 !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy8, done8);
        else pass_cnt++;
    endtask

    task automatic run_table(input string name, input logic [7:0] ta[], input logic [7:0] tb_[],
                             input logic tc[]);
        int         busy_n;
        logic       seen_done;
        logic       held_ok;
        logic [8:0] exp;
        logic       exp_o;
        for (int i = 0; i < ta.size(); i++) begin
            do_op(ta[i], tb_[i], tc[i], busy_n, seen_done, held_ok);
            exp   = exp_q.pop_front();
            exp_o = exp_ovf_q.pop_front();
            total_cnt++;
            if (!seen_done) $display("FAIL %s_timeout[%0d]: no done within 40 cycles, required done", name, i);
            else pass_cnt++;
            total_cnt++;
            if (busy_n !== 8) $display("FAIL %s_busy_len[%0d]: %0d cycles, required 8", name, i, busy_n);
            else pass_cnt++;
            total_cnt++;
            if ({cout8, sum8} !== exp)
                $display("FAIL %s_result[%0d]: cout=%b sum=%0d, required cout=%b sum=%0d",
                         name, i, cout8, sum8, exp[8], exp[7:0]);
            else pass_cnt++;
            total_cnt++;
            if (!held_ok) $display("FAIL %s_hold[%0d]: Sum/Cout changed during RUN, required stable", name, i);
            else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
            total_cnt++;
            if (ovf8 !== exp_o) $display("FAIL %s_ovf[%0d]: ovf=%b, required %b", name, i, ovf8, exp_o);
            else pass_cnt++;
`endif
            @(negedge clk);
            total_cnt++;
            if (done8 !== 1'b0 || busy8 !== 1'b0)
                $display("FAIL %s_done_pulse[%0d]: done=%b busy=%b after DONE, required 0 0", name, i, done8, busy8);
            else pass_cnt++;
        end
    endtask

    task automatic test_add();
        logic [7:0] ta[]  = '{8'd3, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [7:0] tb_[] = '{8'd5, 8'd1,   8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       tc[]  = '{1'b0, 1'b0,   1'b1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 3; i < 8; i++) begin
            ta[i]  = 8'($urandom_range(0, 255));
            tb_[i] = 8'($urandom_range(0, 255));
            tc[i]  = 1'($urandom_range(0, 1));
        end
        run_table("add", ta, tb_, tc);
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta[]  = '{8'd127, 8'd100};
        logic [7:0] tb_[] = '{8'd1,   8'd206};
        logic       tc[]  = '{1'b0,   1'b0};
        run_table("ovf", ta, tb_, tc);
    endtask
`endif

    task automatic test_ignore();
        int         busy_n;
        int         stray;
        logic [8:0] exp;
        logic       exp_o;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; cin8 = 1'b0; start8 = 1'b1;
        exp_q.push_back(9'd3);
        exp_ovf_q.push_back(1'b0);
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (busy8 !== 1'b1) $display("FAIL ignore_busy4: busy=%b in 4th RUN cycle, required 1", busy8);
        else pass_cnt++;
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        busy_n = 4;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy8) busy_n++;
            if (done8) break;
        end
        exp   = exp_q.pop_front();
        exp_o = exp_ovf_q.pop_front();
        total_cnt++;
        if (busy_n !== 8) $display("FAIL ignore_busy_len: %0d cycles, required 8", busy_n);
        else pass_cnt++;
        total_cnt++;
        if (done8 !== 1'b1 || {cout8, sum8} !== exp)
            $display("FAIL ignore_result: done=%b cout=%b sum=%0d, required done=1 cout=%b sum=%0d",
                     done8, cout8, sum8, exp[8], exp[7:0]);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total_cnt++;
        if (ovf8 !== exp_o) $display("FAIL ignore_ovf: ovf=%b, required %b", ovf8, exp_o);
        else pass_cnt++;
`endif
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy8 || done8) stray++;
        end
        total_cnt++;
        if (stray !== 0) $display("FAIL ignore_no_rerun: %0d busy/done cycles after op, required 0", stray);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int   stray;
        int   busy_n;
        logic seen_done;
        logic held_ok;
        logic [8:0] exp;
        logic       exp_o;
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (busy8 !== 1'b1 || sum8 === 8'd0)
            $display("FAIL rstmid_pre: busy=%b sum=%0d, required busy=1 and previous nonzero sum", busy8, sum8);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy8, done8, cout8, sum8} !== 11'd0)
            $display("FAIL rstmid_clear: busy=%b done=%b cout=%b sum=%0d, required all 0", busy8, done8, cout8, sum8);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total_cnt++;
        if (ovf8 !== 1'b0) $display("FAIL rstmid_ovf: ovf=%b, required 0", ovf8);
        else pass_cnt++;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy8 || done8) stray++;
        end
        total_cnt++;
        if (stray !== 0) $display("FAIL rstmid_no_done: %0d busy/done cycles after reset, required 0", stray);
        else pass_cnt++;
        do_op(8'd77, 8'd88, 1'b1, busy_n, seen_done, held_ok);
        exp   = exp_q.pop_front();
        exp_o = exp_ovf_q.pop_front();
        total_cnt++;
        if (!seen_done || busy_n !== 8 || {cout8, sum8} !== exp)
            $display("FAIL rstmid_after: done=%b busy_len=%0d cout=%b sum=%0d, required done=1 busy_len=8 cout=%b sum=%0d",
                     seen_done, busy_n, cout8, sum8, exp[8], exp[7:0]);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total_cnt++;
        if (ovf8 !== exp_o) $display("FAIL rstmid_after_ovf: ovf=%b, required %b", ovf8, exp_o);
        else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [6:0] v;
        logic [3:0] full;
        logic [3:0] exp;
        logic       exp_o;
        int         busy_n;
        logic       seen_done;
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            v = i[6:0];
            a3 = v[6:4]; b3 = v[3:1]; cin3 = v[0]; start3 = 1'b1;
            full = {1'b0, v[6:4]} + {1'b0, v[3:1]} + {3'd0, v[0]};
            exp3_q.push_back(full);
            exp_ovf3_q.push_back((v[6] == v[3]) && (full[2] != v[6]));
            @(posedge clk);
            #1;
            total_cnt++;
            if (busy3 !== 1'b1) $display("FAIL b2b_accept[%0d]: busy=%b after start, required 1", i, busy3);
            else pass_cnt++;
            busy_n = 1; seen_done = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (busy3) busy_n++;
                if (done3) begin
                    seen_done = 1'b1;
                    break;
                end
            end
            // The posedge check above already counted the first busy cycle's start.
            busy_n--;
            exp   = exp3_q.pop_front();
            exp_o = exp_ovf3_q.pop_front();
            total_cnt++;
            if (!seen_done || busy_n !== 3)
                $display("FAIL b2b_timing[%0d]: done=%b busy_len=%0d, required done=1 busy_len=3", i, seen_done, busy_n);
            else pass_cnt++;
            total_cnt++;
            if ({cout3, sum3} !== exp)
                $display("FAIL b2b_result[%0d]: A=%0d B=%0d Cin=%0d cout=%b sum=%0d, required cout=%b sum=%0d",
                         i, v[6:4], v[3:1], v[0], cout3, sum3, exp[3], exp[2:0]);
            else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
            total_cnt++;
            if (ovf3 !== exp_o) $display("FAIL b2b_ovf[%0d]: ovf=%b, required %b", i, ovf3, exp_o);
            else pass_cnt++;
`endif
        end
        start3 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy3 !== 1'b0 || done3 !== 1'b0)
            $display("FAIL b2b_end: busy=%b done=%b after last op, required 0 0", busy3, done3);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ignore();
        test_reset_mid();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
